// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: channel count,
// select type and the select-to-one-hot decode.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

    localparam ch_sel_t CH0 = 2'd0;
    localparam ch_sel_t CH1 = 2'd1;
    localparam ch_sel_t CH2 = 2'd2;
    localparam ch_sel_t CH3 = 2'd3;

    // One-hot channel mask for a select value.
    function automatic logic [NUM_CH-1:0] sel_decode(input ch_sel_t sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One output channel: one-entry holding slot with valid/ready handshake and a
// saturating count of words handed to the consumer.
module demux_out_slot #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic drain;

    assign drain = valid & ready;

    // A load in the same cycle as a drain replaces the word and keeps valid high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // Clear takes priority over a coincident drain; the count never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (drain && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer: routes each accepted word by in_sel
// into one of four independently drained holding slots.
module demux_1x4_stream
    import demux_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    input  logic                     cnt_clr,
    output logic [NUM_CH*CNT_W-1:0]  cnt
);

    logic              sel_full;
    logic              sel_ready;
    logic              accept;
    logic [NUM_CH-1:0] load;

    // State of the addressed slot; only this slot gates acceptance, so a stall
    // on one channel never blocks words bound elsewhere.
    always_comb begin
        sel_full  = 1'b0;
        sel_ready = 1'b0;
        case (ch_sel_t'(in_sel))
            CH0: begin sel_full = out_valid[0]; sel_ready = out_ready[0]; end
            CH1: begin sel_full = out_valid[1]; sel_ready = out_ready[1]; end
            CH2: begin sel_full = out_valid[2]; sel_ready = out_ready[2]; end
            CH3: begin sel_full = out_valid[3]; sel_ready = out_ready[3]; end
        endcase
    end

    // Combinational path from in_sel/out_ready to in_ready.
    assign in_ready = reset_n & (~sel_full | sel_ready);
    assign accept   = in_valid & in_ready;
    assign load     = accept ? sel_decode(ch_sel_t'(in_sel)) : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
        demux_out_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk       (clk),
            .reset_n   (reset_n),
            .load      (load[i]),
            .load_data (in_data),
            .ready     (out_ready[i]),
            .valid     (out_valid[i]),
            .data      (out_data[i*DATA_W +: DATA_W]),
            .cnt_clr   (cnt_clr),
            .cnt       (cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Bench for demux_1x4_stream: directed vector table, corner sequences and
// random traffic checked against a per-channel behavioural model.
module tb_demux_1x4_stream;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_ready;
    logic        cnt_clr;

    logic        in_ready,  in_ready4;
    logic [3:0]  out_valid, out_valid4;
    logic [31:0] out_data,  out_data4;
    logic [31:0] cnt;
    logic [15:0] cnt4;

    int checks   = 0;
    int failures = 0;

    bit         m_valid[4];
    logic [7:0] m_data[4];
    int         m_cnt[4];

    demux_1x4_stream #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .cnt_clr(cnt_clr), .cnt(cnt)
    );

    demux_1x4_stream #(.DATA_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .cnt_clr(cnt_clr), .cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        return reset_n && (!m_valid[in_sel] || out_ready[in_sel]);
    endfunction

    function automatic logic [3:0] exp_valid();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = m_valid[i];
        return r;
    endfunction

    function automatic logic [31:0] exp_data();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = m_data[i];
        return r;
    endfunction

    function automatic logic [31:0] exp_cnt8();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'((m_cnt[i] > 255) ? 255 : m_cnt[i]);
        return r;
    endfunction

    function automatic logic [15:0] exp_cnt4();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'((m_cnt[i] > 15) ? 15 : m_cnt[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = 8'h00;
            m_cnt[i]   = 0;
        end
    endtask

    // Before the edge: check in_ready, then advance the model by one cycle.
    task automatic step_pre();
        logic rdy;
        logic drained;
        logic loaded;
        #1;
        rdy = exp_ready();
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("in_ready_w4", 32'(in_ready4), 32'(rdy));
        for (int i = 0; i < 4; i++) begin
            drained = m_valid[i] && out_ready[i];
            loaded  = in_valid && rdy && (in_sel == 2'(i));
            if (loaded) begin
                m_valid[i] = 1'b1;
                m_data[i]  = in_data;
            end else if (drained) begin
                m_valid[i] = 1'b0;
            end
            if (cnt_clr) m_cnt[i] = 0;
            else if (drained) m_cnt[i]++;
        end
    endtask

    task automatic step_post();
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(exp_valid()));
        chk("out_data", out_data, exp_data());
        chk("cnt", cnt, exp_cnt8());
        chk("out_valid_w4", 32'(out_valid4), 32'(exp_valid()));
        chk("out_data_w4", out_data4, exp_data());
        chk("cnt_w4", 32'(cnt4), 32'(exp_cnt4()));
    endtask

    task automatic apply(input logic v, input logic [1:0] sel, input logic [7:0] d,
                         input logic [3:0] ordy, input logic clr);
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        cnt_clr   = clr;
        step_pre();
        step_post();
    endtask

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [7:0] data;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // routing with all consumers ready, then backpressure on ch1
        vecs[0] = '{1'b1, 2'd0, 8'hA0, 4'b1111, 1'b1, 4'b0001};
        vecs[1] = '{1'b1, 2'd1, 8'hA1, 4'b1111, 1'b1, 4'b0010};
        vecs[2] = '{1'b1, 2'd2, 8'hA2, 4'b1111, 1'b1, 4'b0100};
        vecs[3] = '{1'b1, 2'd3, 8'hA3, 4'b1111, 1'b1, 4'b1000};
        vecs[4] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000};
        vecs[5] = '{1'b1, 2'd1, 8'h55, 4'b1101, 1'b1, 4'b0010};
        vecs[6] = '{1'b1, 2'd1, 8'h66, 4'b1101, 1'b0, 4'b0010};
        vecs[7] = '{1'b1, 2'd3, 8'h77, 4'b1101, 1'b1, 4'b1010};
        vecs[8] = '{1'b1, 2'd1, 8'h66, 4'b1111, 1'b1, 4'b0010};
        vecs[9] = '{1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = 8'h00;
        out_ready = 4'b0000;
        cnt_clr   = 1'b0;
        model_reset();
        #3;
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_cnt", cnt, 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'h1);

        for (int k = 0; k < 10; k++) begin
            in_valid  = vecs[k].v;
            in_sel    = vecs[k].sel;
            in_data   = vecs[k].data;
            out_ready = vecs[k].ordy;
            cnt_clr   = 1'b0;
            step_pre();
            chk($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(vecs[k].exp_rdy));
            step_post();
            chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(vecs[k].exp_ov));
            if (k == 4) chk("routing_cnt", cnt, 32'h01010101);
            if (k == 6) chk("stall_hold_ch1", 32'(out_data[15:8]), 32'h55);
        end
        chk("table_end_cnt", cnt, 32'h02010301);

        // streaming to ch0 without bubbles
        apply(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
        for (int k = 0; k < 16; k++) begin
            in_valid  = 1'b1;
            in_sel    = 2'd0;
            in_data   = 8'(8'h10 + k);
            out_ready = 4'b0001;
            cnt_clr   = 1'b0;
            step_pre();
            chk("stream_in_ready", 32'(in_ready), 32'h1);
            step_post();
        end
        apply(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0);
        chk("stream_cnt0", 32'(cnt[7:0]), 32'd16);
        chk("stream_cnt0_w4", 32'(cnt4[3:0]), 32'd15);

        // saturation on ch3, then clear coincident with a drain
        apply(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1);
        for (int k = 0; k < 20; k++) apply(1'b1, 2'd3, 8'($urandom), 4'b1000, 1'b0);
        apply(1'b0, 2'd0, 8'h00, 4'b1000, 1'b0);
        chk("sat_cnt3_w4", 32'(cnt4[15:12]), 32'd15);
        chk("sat_cnt3", 32'(cnt[31:24]), 32'd20);
        apply(1'b1, 2'd3, 8'hE7, 4'b0000, 1'b0);
        apply(1'b0, 2'd0, 8'h00, 4'b1000, 1'b1);
        chk("clr_vs_drain_w4", 32'(cnt4[15:12]), 32'd0);
        chk("clr_vs_drain", 32'(cnt[31:24]), 32'd0);

        // all four slots drain in one cycle
        apply(1'b0, 2'd0, 8'h00, 4'b0000, 1'b1);
        for (int k = 0; k < 4; k++) apply(1'b1, 2'(k), 8'(8'hB0 + k), 4'b0000, 1'b0);
        chk("all_full", 32'(out_valid), 32'hF);
        apply(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
        chk("all_drained", 32'(out_valid), 32'h0);
        chk("all_cnt", cnt, 32'h01010101);
        chk("all_cnt_w4", 32'(cnt4), 32'h1111);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            apply($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom),
                  4'($urandom), $urandom_range(0, 15) == 0);
        end

        // asynchronous reset mid-transfer with ch2 full
        apply(1'b1, 2'd2, 8'hC3, 4'b0000, 1'b0);
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 8'h3C;
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(out_valid), 32'h0);
        chk("midreset_cnt", cnt, 32'h0);
        chk("midreset_cnt_w4", 32'(cnt4), 32'h0);
        chk("midreset_out_data", out_data, 32'h0);
        chk("midreset_in_ready", 32'(in_ready), 32'h0);
        model_reset();
        in_valid = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
        chk("midrelease_in_ready", 32'(in_ready), 32'h1);
        apply(1'b1, 2'd2, 8'h5A, 4'b0000, 1'b0);
        chk("post_reset_load", 32'(out_valid), 32'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1x4_stream.md
Name: demux_1x4_stream

Overview:
- Registered 1-to-4 stream demultiplexer: the distribution-side counterpart of the 4:1 select mux.
- Accepts one data word per valid/ready handshake and routes it by a 2-bit select to one of four output channels.
- Each output channel has a one-entry holding slot with its own valid/ready handshake and a saturating delivered-word counter.
- Sits between a single producer and four independent consumers.

Parameters:
- DATA_W, 8, width of each data word.
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset; assertion clears all state immediately; release synchronous to clk.
- in_valid  input  1  producer offers in_data/in_sel.
- in_ready  output  1  block can accept this cycle.
- in_data  input  DATA_W  word to route.
- in_sel  input  2  destination channel; 00→ch0, 01→ch1, 10→ch2, 11→ch3.
- out_valid  output  4  bit i: channel i slot holds a word.
- out_ready  input  4  bit i: consumer i takes the word this cycle.
- out_data  output  4*DATA_W  channel i word at bits [i*DATA_W +: DATA_W].
- cnt_clr  input  1  synchronous clear of all counters.
- cnt  output  4*CNT_W  channel i delivered count at bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (reset_n=0), asynchronous:
  - out_valid=0, out_data=0, cnt=0.
  - in_ready forced 0.
  - Buffered words are discarded, including on reset mid-operation.
- Slot full state: full[i] = out_valid[i].
- Ready: in_ready = reset_n & (~full[in_sel] | out_ready[in_sel]). This is combinational from in_sel/out_ready and is documented as a timing path.
- Accept: in_valid & in_ready.
  - Selected slot loads in_data on that edge; out_valid[sel]=1 from the next cycle. Latency is 1 cycle.
  - in_sel is sampled only on accept.
- Drain: out_valid[i] & out_ready[i]. Slot i empties on that edge unless it is refilled in the same cycle.
- Simultaneous drain and fill of the same slot: new word replaces old, out_valid stays 1. Throughput is 1 word/cycle to one channel.
- Slot full with no drain: in_ready=0 for that sel. A word for a different channel is still accepted (no head-of-line blocking on the select value itself; the producer may change in_sel while stalled).
- Stability: out_data[i] is held stable while out_valid[i]=1 and out_ready[i]=0. Idle slots keep their last data.
- Independence: the four drains are independent and may all occur in one cycle.
- Counters:
  - cnt[i] increments by 1 on each drain of channel i.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 sets all counters to 0 on the next edge; clear wins over a coincident drain.
- No X propagation: out_data is never driven from an unloaded slot after reset.

Decomposition:
- Shared package demux_pkg:
  - NUM_CH=4 constant.
  - ch_sel_t (2-bit logic typedef).
  - CH0..CH3 select constants.
- Sub-module demux_out_slot, instantiated 4×. Holds:
  - one-entry register and valid flag;
  - load/drain logic;
  - saturating counter with clear.
  - Ports: clk, reset_n, load, load_data, ready, valid, data, cnt_clr, cnt.
- Top level holds: select decode, in_ready mux, and flattening of out_data/cnt.

Test Plan:
- Reset/idle:
  - Assert reset_n=0 mid-transfer with ch2 full → immediately out_valid=0000, cnt=0, in_ready=0.
  - Release with in_valid=0 → in_ready=1.
- Basic routing:
  - Send 0xA0,0xA1,0xA2,0xA3 with sel 0..3 and out_ready=1111 → each appears on its channel one cycle after accept.
  - Result: cnt = 1,1,1,1.
- Backpressure:
  - out_ready[1]=0; send 0x55 to ch1, then 0x66 to ch1 → in_ready=0 on second word; out_data[1] stays 0x55.
  - Then send 0x77 to ch3 → accepted.
  - Raise out_ready[1] → 0x66 accepted that same cycle, out_valid[1] stays 1.
- Streaming:
  - 16 back-to-back words to ch0 with out_ready[0]=1 → in_ready=1 every cycle, no bubble, cnt[0]=16.
- Saturation and clear:
  - CNT_W=4; 20 drains on ch3 → cnt[3]=15.
  - cnt_clr coincident with a drain → cnt[3]=0 next cycle.
- Concurrent drains:
  - All four slots full, out_ready=1111 for one cycle → out_valid=0000 next cycle; every counter +1.
